// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
// Mux-select and ALU encodings match what the datapath muxes expect.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StTrap
  } state_t;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_t;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OpStore:  return ImmS;
      OpBranch: return ImmB;
      OpJal:    return ImmJ;
      default:  return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Maps the FSM's ALU operation class plus funct fields onto the ALU control code.
// bad_funct flags funct3 values the datapath ALU cannot execute.
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7_5,
  output logic [2:0] alu_control,
  output logic       bad_funct
);

  always_comb begin
    alu_control = AluAdd;
    bad_funct   = 1'b0;
    case (alu_op)
      AluOpAdd: alu_control = AluAdd;
      AluOpSub: alu_control = AluSub;
      AluOpFunct: begin
        case (funct3)
          // op5 separates R-type from I-type so addi with imm[10] set still adds
          3'b000:  alu_control = (op5 && funct7_5) ? AluSub : AluAdd;
          3'b010:  alu_control = AluSlt;
          3'b110:  alu_control = AluOr;
          3'b111:  alu_control = AluAnd;
          default: bad_funct = 1'b1;
        endcase
      end
      default: alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the shared-ALU multi-cycle RV32I datapath: sequences each instruction
// and drives every datapath select/enable; parks in a sticky trap on unsupported encodings.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [2:0]            ALUControl,
  output logic                  retire,
  output logic                  illegal
);

  state_t     state_q, state_d;
  alu_op_t    alu_op;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       pc_update;
  logic       branch;
  logic       branch_ok;
  logic       bad_funct;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign branch_ok    = (funct3[2:1] == 2'b00);
  assign unused_instr = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

  multicycle_control_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (instr[5]),
    .funct7_5    (instr[30]),
    .alu_control (ALUControl),
    .bad_funct   (bad_funct)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR, StExecI: state_d = bad_funct ? StTrap : StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = branch_ok ? StFetch : StTrap;
      StJal:      state_d = StAluWb;
      StTrap:     state_d = StTrap;
      default:    state_d = StTrap;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = ResAluOut;
    ALUSrcA   = SrcAPc;
    ALUSrcB   = SrcBRd2;
    ImmSrc    = ImmI;
    retire    = 1'b0;
    illegal   = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    alu_op    = AluOpAdd;
    case (state_q)
      StFetch: begin
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
      end
      StDecode: begin
        // ALU precomputes OldPC+imm so the branch target sits in ALUOut
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
        ImmSrc  = imm_src_of(opcode);
      end
      StMemAdr: begin
        ALUSrcA = SrcARd1;
        ALUSrcB = SrcBImm;
        ImmSrc  = imm_src_of(opcode);
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = ResData;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
      end
      StExecR: begin
        ALUSrcA = SrcARd1;
        ALUSrcB = SrcBRd2;
        alu_op  = AluOpFunct;
      end
      StExecI: begin
        ALUSrcA = SrcARd1;
        ALUSrcB = SrcBImm;
        ImmSrc  = imm_src_of(opcode);
        alu_op  = AluOpFunct;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      StBranch: begin
        ALUSrcA = SrcARd1;
        ALUSrcB = SrcBRd2;
        alu_op  = AluOpSub;
        branch  = branch_ok;
        retire  = branch_ok;
      end
      StJal: begin
        ALUSrcA   = SrcAOldPc;
        ALUSrcB   = SrcBFour;
        pc_update = 1'b1;
      end
      StTrap:  illegal = 1'b1;
      default: ;
    endcase
    // funct3[0] inverts the zero test: beq takes on zero, bne on non-zero
    PCWrite = pc_update | (branch & (zero ^ funct3[0]));
    if (rst) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output sequences plus
// hand-computed latency and enable-count checks.
module tb_multicycle_control;

  logic        clk, rst, zero, mem_ready;
  logic [31:0] instr, next_instr;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;

  multicycle_control #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .retire     (retire),
    .illegal    (illegal)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [17:0] v;
    logic [17:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int cyc_n = 0, retire_cnt = 0, last_retire = 0, mw_cnt = 0, rw_cnt = 0;

  // Only the enables are defined while rst is high
  localparam logic [17:0] EnMask  = 18'h2E003;
  localparam logic [17:0] AllMask = 18'h3FFFF;

  function automatic logic [17:0] vec(input logic pcw, adr, mw, irw, rw,
                                      input logic [1:0] rs, a, b, imm,
                                      input logic [2:0] alu, input logic ret, ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ret, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [31:0] ins);
    case (ins[6:0])
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // {unsupported, ALUControl} for R/I arithmetic
  function automatic logic [3:0] alu_of(input logic [31:0] ins);
    logic is_sub;
    is_sub = (ins[6:0] == 7'b0110011) && ins[30];
    case (ins[14:12])
      3'b000:  return {1'b0, is_sub ? 3'b001 : 3'b000};
      3'b010:  return 4'b0101;
      3'b110:  return 4'b0011;
      3'b111:  return 4'b0010;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [17:0] v_fetch(input logic rd);
    return vec(rd, 0, 0, rd, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] v_trap();
    return vec(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1);
  endfunction
  function automatic logic [17:0] v_memadr(input logic [31:0] ins);
    return vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm_of(ins), 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] v_memwrite(input logic rd);
    return vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, rd, 0);
  endfunction

  always @(negedge clk) begin
    logic [17:0] act;
    exp_t e;
    act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
           ALUControl, retire, illegal};
    cyc_n++;
    if (retire) begin
      retire_cnt++;
      last_retire = cyc_n;
    end
    if (MemWrite) mw_cnt++;
    if (RegWrite) rw_cnt++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ((act & e.mask) !== (e.v & e.mask)) begin
        errors++;
        $display("FAIL %s cycle %0d: got %05h expected %05h (mask %05h)",
                 e.name, cyc_n, act, e.v, e.mask);
      end
    end
  end

  task automatic cyc(input logic r, rd, z, input logic [17:0] v, m, input string nm);
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = rd;
    zero      = z;
    instr     = next_instr;
    exp_q.push_back('{nm, v, m});
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic z, input int fstall,
                           input int mstall, input string nm);
    logic [3:0] a;
    logic       legal;
    a     = alu_of(ins);
    legal = (ins[14:13] == 2'b00);
    next_instr = ins;
    for (int i = 0; i < fstall; i++) cyc(0, 0, z, v_fetch(0), AllMask, {nm, " fetch-wait"});
    cyc(0, 1, z, v_fetch(1), AllMask, {nm, " fetch"});
    cyc(0, 1, z, vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm_of(ins), 3'b000, 0, 0), AllMask,
        {nm, " decode"});
    case (ins[6:0])
      7'b0000011: begin
        cyc(0, 1, z, v_memadr(ins), AllMask, {nm, " memadr"});
        for (int i = 0; i < mstall; i++)
          cyc(0, 0, z, vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), AllMask,
              {nm, " memread-wait"});
        cyc(0, 1, z, vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), AllMask,
            {nm, " memread"});
        cyc(0, 1, z, vec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0), AllMask,
            {nm, " memwb"});
      end
      7'b0100011: begin
        cyc(0, 1, z, v_memadr(ins), AllMask, {nm, " memadr"});
        for (int i = 0; i < mstall; i++)
          cyc(0, 0, z, v_memwrite(0), AllMask, {nm, " memwrite-wait"});
        cyc(0, 1, z, v_memwrite(1), AllMask, {nm, " memwrite"});
      end
      7'b0110011, 7'b0010011: begin
        if (ins[6:0] == 7'b0110011)
          cyc(0, 1, z, vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, a[2:0], 0, 0), AllMask,
              {nm, " execr"});
        else
          cyc(0, 1, z, vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, a[2:0], 0, 0), AllMask,
              {nm, " execi"});
        if (a[3]) cyc(0, 1, z, v_trap(), AllMask, {nm, " trap"});
        else
          cyc(0, 1, z, vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0), AllMask,
              {nm, " aluwb"});
      end
      7'b1100011: begin
        cyc(0, 1, z, vec(legal & (z ^ ins[12]), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001,
                         legal, 0), AllMask, {nm, " branch"});
        if (!legal) cyc(0, 1, z, v_trap(), AllMask, {nm, " trap"});
      end
      7'b1101111: begin
        cyc(0, 1, z, vec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 0, 0), AllMask,
            {nm, " jal"});
        cyc(0, 1, z, vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0), AllMask,
            {nm, " aluwb"});
      end
      default: cyc(0, 1, z, v_trap(), AllMask, {nm, " trap"});
    endcase
  endtask

  task automatic timed(input logic [31:0] ins, input logic z, input int fstall, input int mstall,
                       input string nm, input int exp_lat);
    int start, r0;
    start = cyc_n;
    r0    = retire_cnt;
    run_instr(ins, z, fstall, mstall, nm);
    settle();
    check_int({nm, " latency"}, last_retire - start, exp_lat);
    check_int({nm, " retires"}, retire_cnt - r0, 1);
  endtask

  initial begin
    int r0, m0, w0;
    rst        = 1'b1;
    mem_ready  = 1'b1;
    zero       = 1'b0;
    instr      = 32'h0;
    next_instr = 32'h0;
    exp_q.push_back('{"reset", 18'h0, EnMask});
    settle();

    w0 = rw_cnt;
    timed(32'h002081B3, 0, 0, 0, "add", 4);
    check_int("add regwrites", rw_cnt - w0, 1);
    timed(32'h402081B3, 0, 0, 0, "sub", 4);
    timed(32'h0020E1B3, 0, 0, 0, "or", 4);
    timed(32'h0020F1B3, 0, 0, 0, "and", 4);
    timed(32'h0020A1B3, 0, 0, 0, "slt", 4);
    timed(32'h00500093, 0, 0, 0, "addi", 4);
    timed(32'h40000093, 0, 0, 0, "addi-bit30", 4);
    timed(32'h0050A093, 0, 0, 0, "slti", 4);
    timed(32'h0FF0F093, 0, 0, 0, "andi", 4);
    timed(32'h0010E093, 0, 0, 0, "ori", 4);
    timed(32'h002081B3, 0, 2, 0, "add-fetch-stall", 6);
    timed(32'h00802283, 0, 0, 2, "lw", 7);

    m0 = mw_cnt;
    w0 = rw_cnt;
    timed(32'h00502223, 0, 0, 1, "sw", 5);
    check_int("sw memwrite cycles", mw_cnt - m0, 2);
    check_int("sw regwrites", rw_cnt - w0, 0);

    timed(32'h00208463, 1, 0, 0, "beq-taken", 3);
    timed(32'h00208463, 0, 0, 0, "beq-not-taken", 3);
    timed(32'h00209463, 1, 0, 0, "bne-not-taken", 3);
    timed(32'h00209463, 0, 0, 0, "bne-taken", 3);
    timed(32'h008000EF, 0, 0, 0, "jal", 4);

    // Unsupported opcode: sticky trap, cleared only by reset
    r0 = retire_cnt;
    run_instr(32'h0000007F, 0, 0, 0, "opcode-7f");
    cyc(0, 0, 0, v_trap(), AllMask, "trap sticky a");
    cyc(0, 1, 1, v_trap(), AllMask, "trap sticky b");
    cyc(1, 1, 0, 18'h0, EnMask, "trap reset");
    run_instr(32'h002081B3, 0, 0, 0, "add after trap");

    run_instr(32'h0020C463, 1, 0, 0, "blt-unsupported");
    cyc(1, 1, 0, 18'h0, EnMask, "blt reset");
    run_instr(32'h002091B3, 0, 0, 0, "sll-unsupported");
    cyc(1, 1, 0, 18'h0, EnMask, "sll reset");
    settle();
    check_int("retires across traps", retire_cnt - r0, 1);

    // Reset lands while a store waits on memory
    r0 = retire_cnt;
    m0 = mw_cnt;
    next_instr = 32'h00502223;
    cyc(0, 1, 0, v_fetch(1), AllMask, "swrst fetch");
    cyc(0, 1, 0, vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0, 0), AllMask,
        "swrst decode");
    cyc(0, 1, 0, v_memadr(32'h00502223), AllMask, "swrst memadr");
    cyc(0, 0, 0, v_memwrite(0), AllMask, "swrst memwrite-wait");
    cyc(1, 1, 0, 18'h0, EnMask, "swrst reset");
    run_instr(32'h002081B3, 0, 0, 0, "add after swrst");
    settle();
    check_int("swrst memwrite cycles", mw_cnt - m0, 1);
    check_int("swrst retires", retire_cnt - r0, 1);

    check_int("expectations drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
